// File: rtl/main_memory_responder.sv
// Block-oriented main memory model: 1024 bytes accessed as 16-byte blocks,
// fixed LATENCY per request. Define MEM_INIT_PATTERN_EN to reset memory[i] = i[7:0].
module main_memory_responder #(
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_from_cache,
    input  logic         read_write_from_cache,
    input  logic [9:0]   address_from_cache,
    input  logic [127:0] write_block_from_cache,
    output logic [127:0] read_block_out,
    output logic         ready_out,
    output logic         busy_out
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     counter_reg, counter_next;
    logic           op_reg, op_next;
    logic [9:0]     base_reg, base_next;
    logic [127:0]   wblock_reg, wblock_next;
    logic           mem_write;
    logic           read_load;
    logic [127:0]   read_gather;

    logic [7:0]     memory [0:1023];

    // Offset bits are masked off so the stored base is always block aligned.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        op_next      = op_reg;
        base_next    = base_reg;
        wblock_next  = wblock_reg;
        mem_write    = 1'b0;
        read_load    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_from_cache) begin
                    op_next      = read_write_from_cache;
                    base_next    = address_from_cache & 10'h3F0;
                    wblock_next  = write_block_from_cache;
                    counter_next = LAT_M1;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (counter_reg == 4'd0) begin
                    state_next = RESPOND;
                    mem_write  = op_reg;
                    read_load  = ~op_reg;
                end else begin
                    counter_next = counter_reg - 4'd1;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            counter_reg <= 4'd0;
            op_reg      <= 1'b0;
            base_reg    <= 10'd0;
            wblock_reg  <= 128'd0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            op_reg      <= op_next;
            base_reg    <= base_next;
            wblock_reg  <= wblock_next;
        end
    end

    // Whole-array reset rules out block RAM; this is a register-file memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) begin
`ifdef MEM_INIT_PATTERN_EN
                memory[i] <= 8'(i);
`else
                memory[i] <= 8'h00;
`endif
            end
        end else if (mem_write) begin
            for (int k = 0; k < 16; k++) begin
                memory[base_reg | 10'(k)] <= wblock_reg[8*k +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign read_gather[8*gi +: 8] = memory[base_reg | 10'(gi)];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            read_block_out <= 128'h0;
        end else if (read_load) begin
            read_block_out <= read_gather;
        end
    end

    assign ready_out = (state_reg == RESPOND);
    assign busy_out  = (state_reg != IDLE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: reference byte model, expected
// read blocks queued at issue and compared when ready_out pulses.
module tb_main_memory_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_from_cache;
    logic         read_write_from_cache;
    logic [9:0]   address_from_cache;
    logic [127:0] write_block_from_cache;
    logic [127:0] read_block_out;
    logic         ready_out;
    logic         busy_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]   model_mem [0:1023];
    logic [127:0] exp_q [$];
    logic [127:0] last_read;

    main_memory_responder #(.LATENCY(LAT)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_from_cache         (req_from_cache),
        .read_write_from_cache  (read_write_from_cache),
        .address_from_cache     (address_from_cache),
        .write_block_from_cache (write_block_from_cache),
        .read_block_out         (read_block_out),
        .ready_out              (ready_out),
        .busy_out               (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 1024; i++) begin
`ifdef MEM_INIT_PATTERN_EN
            model_mem[i] = 8'(i);
`else
            model_mem[i] = 8'h00;
`endif
        end
    endfunction

    function automatic logic [127:0] model_block(input logic [9:0] addr);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = model_mem[{addr[9:4], 4'(k)}];
        return b;
    endfunction

    // One request; optionally re-asserts a write request during WAIT, which must be ignored.
    task automatic run_txn(input logic op, input logic [9:0] addr, input logic [127:0] data,
                           input bit second_req);
        int edges;
        int busy_cycles;
        bit seen;
        @(negedge clk);
        req_from_cache         = 1'b1;
        read_write_from_cache  = op;
        address_from_cache     = addr;
        write_block_from_cache = data;
        if (!op) exp_q.push_back(model_block(addr));
        @(posedge clk); #1;
        busy_cycles = busy_out ? 1 : 0;
        check("busy_on_accept", 128'(busy_out), 128'd1);
        // Scramble inputs: the in-flight operation must not see them.
        req_from_cache         = second_req;
        read_write_from_cache  = 1'b1;
        address_from_cache     = addr ^ 10'h0C0;
        write_block_from_cache = ~data;
        edges = 0;
        seen  = 1'b0;
        while (edges < 40 && !seen) begin
            @(posedge clk); #1;
            edges++;
            if (busy_out) busy_cycles++;
            req_from_cache = 1'b0;
            if (ready_out) seen = 1'b1;
        end
        check("ready_seen", 128'(seen), 128'd1);
        check("latency_edges", 128'(edges), 128'(LAT));
        check("busy_cycles", 128'(busy_cycles), 128'(LAT + 1));
        if (op) begin
            for (int k = 0; k < 16; k++) model_mem[{addr[9:4], 4'(k)}] = data[8*k +: 8];
            check("rd_held_on_write", read_block_out, last_read);
        end else if (exp_q.size() > 0) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            check("read_block", read_block_out, e);
            last_read = e;
        end
        $display("txn %s addr=%h data=%h rd=%h edges=%0d", op ? "WR" : "RD", addr, data, read_block_out, edges);
        @(posedge clk); #1;
        check("ready_one_cycle", 128'(ready_out), 128'd0);
        check("busy_idle", 128'(busy_out), 128'd0);
    endtask

    task automatic expect_quiet(input int cycles);
        int pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (ready_out || busy_out) pulses++;
        end
        check("quiet_idle", 128'(pulses), 128'd0);
    endtask

    initial begin
        logic [9:0]   a;
        logic [127:0] d;
        reset = 1'b1;
        req_from_cache = 1'b0;
        read_write_from_cache = 1'b0;
        address_from_cache = '0;
        write_block_from_cache = '0;
        model_reset();
        last_read = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 128'(ready_out), 128'd0);
        check("rst_busy", 128'(busy_out), 128'd0);
        check("rst_rdblk", read_block_out, 128'd0);
        check("rst_mem5", 128'(dut.memory[5]), 128'(model_mem[5]));
        @(negedge clk); reset = 1'b0;

        run_txn(1'b0, 10'h000, '0, 1'b0);
        run_txn(1'b1, 10'h200, 128'hFF, 1'b0);
        for (int k = 0; k < 16; k++)
            check("wr200_byte", 128'(dut.memory[10'h200 + 10'(k)]), (k == 0) ? 128'hFF : 128'h00);
        run_txn(1'b0, 10'h200, '0, 1'b0);
        run_txn(1'b0, 10'h20F, '0, 1'b0);
        check("offset_ignored", read_block_out, 128'hFF);
        run_txn(1'b0, 10'h010, '0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            a = 10'($urandom_range(0, 1023));
            d = {$urandom, $urandom, $urandom, $urandom};
            run_txn(1'b1, a, d, 1'b0);
            run_txn(1'b0, a ^ 10'h00F, '0, 1'b0);
        end

        // Second request during WAIT must be dropped; its target block stays untouched.
        run_txn(1'b0, 10'h040, 128'h1234, 1'b1);
        expect_quiet(6);
        run_txn(1'b0, 10'h040 ^ 10'h0C0, '0, 1'b0);

        // Reset two cycles into a write: write aborted, no ready pulse.
        @(negedge clk);
        req_from_cache = 1'b1;
        read_write_from_cache = 1'b1;
        address_from_cache = 10'h300;
        write_block_from_cache = {16{8'hA5}};
        @(negedge clk); req_from_cache = 1'b0;
        @(negedge clk); reset = 1'b1;
        model_reset();
        last_read = '0;
        @(posedge clk); #1;
        check("abort_busy", 128'(busy_out), 128'd0);
        check("abort_ready", 128'(ready_out), 128'd0);
        check("abort_rdblk", read_block_out, 128'd0);
        @(negedge clk); reset = 1'b0;
        expect_quiet(8);
        for (int k = 0; k < 16; k++)
            check("abort_mem", 128'(dut.memory[10'h300 + 10'(k)]), 128'(model_mem[10'h300 + 10'(k)]));
        run_txn(1'b0, 10'h300, '0, 1'b0);

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
